// File: rtl/conv_column_writer_if.sv
// Column-in / memory-write bus of the column writer.
// The slave side is the writer itself; the master side is the upstream
// convolution engine together with the feature-map memory.
interface conv_column_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_SIZE   = 24,
    parameter int NUM_COLS   = 24,
    parameter int WORD_WIDTH = 256,
    parameter int ADDR_WIDTH = 12
);
    localparam int COL_NUM_W = $clog2(NUM_COLS) + 1;

    // Column pulse from the engine
    logic                  col_valid;
    logic [COL_NUM_W-1:0]  col_num;
    logic [DATA_WIDTH-1:0] col_data [OUT_SIZE-1:0];
    logic                  col_ready;

    // Word write port towards the feature-map memory
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;

    modport master (
        output col_valid, col_num, col_data, mem_ready,
        input  col_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  col_valid, col_num, col_data, mem_ready,
        output col_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/conv_column_writer.sv
// Column writer: captures completed output columns into a 2-entry FIFO and
// stores each one as WORDS_PER_COL consecutive memory words in the same
// column-major layout the convolution engines read. Signals done after
// NUM_COLS columns have actually been written.
module conv_column_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_SIZE   = 24,
    parameter int NUM_COLS   = 24,
    parameter int WORD_WIDTH = 256,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    conv_column_writer_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int LANES         = WORD_WIDTH / DATA_WIDTH;
    localparam int WORDS_PER_COL = (OUT_SIZE + LANES - 1) / LANES;
    localparam int COL_NUM_W     = $clog2(NUM_COLS) + 1;
    localparam int CNT_W         = $clog2(NUM_COLS + 1);
    localparam int WIDX_W        = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
    localparam int COL_BITS      = OUT_SIZE * DATA_WIDTH;
    localparam int PAD_BITS      = WORDS_PER_COL * WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, COMPLETE} state_t;

    state_t               state;
    logic [1:0]           occ;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [WIDX_W-1:0]    word_idx;
    logic [CNT_W-1:0]     col_cnt;

    logic [COL_NUM_W-1:0] fifo_num  [2];
    logic [COL_BITS-1:0]  fifo_data [2];

    logic [COL_BITS-1:0]  col_packed;
    logic [PAD_BITS-1:0]  head_padded;
    logic                 can_accept;
    logic                 wr_active;
    logic                 xfer;
    logic                 last_word;
    logic                 pop;
    logic                 finish;
    logic                 in_range;
    logic                 capture;

    // All outputs decode flops only, so there is no input-to-output path.
    assign can_accept = (state == RUN) && (occ != 2'd2);
    assign wr_active  = (state == RUN) && (occ != 2'd0);
    assign xfer       = wr_active && bus.mem_ready;
    assign last_word  = (word_idx == WIDX_W'(WORDS_PER_COL - 1));
    assign pop        = xfer && last_word;
    // The write that completes the frame flushes the FIFO, so a column
    // captured on that same edge is discarded and flagged.
    assign finish     = pop && (col_cnt == CNT_W'(NUM_COLS - 1));
    assign in_range   = (bus.col_num < COL_NUM_W'(NUM_COLS));
    assign capture    = bus.col_valid && can_accept && in_range && !finish;

    // Flatten the incoming column so element k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
    always_comb begin
        col_packed = '0;
        for (int k = 0; k < OUT_SIZE; k++) begin
            col_packed[k*DATA_WIDTH +: DATA_WIDTH] = bus.col_data[k];
        end
    end

    // Zero-pad the head column to whole words; lanes past OUT_SIZE read as 0.
    always_comb begin
        head_padded = '0;
        head_padded[COL_BITS-1:0] = fifo_data[rd_ptr];
    end

    assign bus.col_ready = can_accept;
    assign bus.mem_we    = wr_active;
    assign bus.mem_addr  = wr_active
                         ? (ADDR_WIDTH'(BASE_ADDR)
                            + ADDR_WIDTH'(fifo_num[rd_ptr]) * ADDR_WIDTH'(WORDS_PER_COL)
                            + ADDR_WIDTH'(word_idx))
                         : '0;
    assign bus.mem_wdata = wr_active ? head_padded[word_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign busy          = (state != IDLE);
    assign done          = (state == COMPLETE);

    // Control FSM: frame arming, FIFO occupancy, word/column counters, sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            word_idx <= '0;
            col_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        occ      <= 2'd0;
                        wr_ptr   <= 1'b0;
                        rd_ptr   <= 1'b0;
                        word_idx <= '0;
                        col_cnt  <= '0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.col_valid && !capture) begin
                        overflow <= 1'b1;
                    end
                    if (xfer) begin
                        word_idx <= last_word ? '0 : word_idx + WIDX_W'(1);
                    end
                    if (finish) begin
                        state   <= COMPLETE;
                        occ     <= 2'd0;
                        wr_ptr  <= 1'b0;
                        rd_ptr  <= 1'b0;
                        col_cnt <= col_cnt + CNT_W'(1);
                    end else begin
                        if (capture) begin
                            wr_ptr <= ~wr_ptr;
                        end
                        if (pop) begin
                            rd_ptr  <= ~rd_ptr;
                            col_cnt <= col_cnt + CNT_W'(1);
                        end
                        if (capture && !pop) begin
                            occ <= occ + 2'd1;
                        end else if (pop && !capture) begin
                            occ <= occ - 2'd1;
                        end
                    end
                end
                COMPLETE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage: data only, validity is tracked by occ so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_num[wr_ptr]  <= bus.col_num;
            fifo_data[wr_ptr] <= col_packed;
        end
    end
endmodule
